scarv_cop_mem_arb: RTL and testbench
====================================

// Module: scarv_cop_mem_arb
//
// PURPOSE
//  Shares one word-aligned memory port between the host CPU data port and the
//  COP memory port (cen/wen/addr/wdata/ben/stall/error protocol).
//  - Picks a winner, holds the grant through memory stalls, and returns each
//    read/error response to the requester that issued the access.
//  - Sits between scarv_cop_top/CPU and the memory; the COP needs no changes.
//
// PARAMETERS
//  ARB_MODE      1  1 = round-robin, 0 = fixed priority CPU with COP anti-starvation
//  STARVE_LIMIT  4  ARB_MODE=0: COP wait cycles before a forced COP grant (1..15)
//
// PORTS
//  g_clk          in   1   Global clock
//  g_resetn       in   1   Synchronous active low reset
//  g_clk_req      out  1   Clock request: cpu_mem_cen | cop_mem_cen | resp_pend
//  cpu_mem_cen    in   1   CPU request; cpu_mem_wen/addr/wdata/ben (1/32/32/4) in
//  cpu_mem_rdata  out  32  CPU read data
//  cpu_mem_stall  out  1   CPU stall
//  cpu_mem_error  out  1   CPU error
//  cop_mem_cen    in   1   COP request; cop_mem_wen/addr/wdata/ben (1/32/32/4) in
//  cop_mem_rdata  out  32  COP read data
//  cop_mem_stall  out  1   COP stall
//  cop_mem_error  out  1   COP error
//  mem_cen        out  1   Shared port chip enable
//  mem_wen        out  1   Shared port write enable
//  mem_addr       out  32  Shared port address (word aligned)
//  mem_wdata      out  32  Shared port write data
//  mem_ben        out  4   Shared port byte enables
//  mem_rdata      in   32  Shared port read data
//  mem_stall      in   1   Shared port stall
//  mem_error      in   1   Shared port error
//
// BEHAVIOUR
//  - Accept: access is accepted in the cycle (mem_cen & !mem_stall).
//  - Response: rdata/error are valid the next cycle (resp cycle); one access
//    outstanding at a time. A new access may be presented in the resp cycle.
//  - State: lock (1b), owner (1b), resp_pend (1b), resp_owner (1b),
//    last_win (1b), cop_wait (4b saturating).
//  - UNLOCKED: winner chosen combinationally from this cycle's cen inputs; its
//    wen/addr/wdata/ben drive mem_* the same cycle (zero-latency path).
//    - If mem_stall=1, set lock and owner=winner.
//    - No requests: mem_cen=0; other mem_* outputs are don't-care.
//  - LOCKED: owner's signals drive mem_* regardless of new requests. Clear lock
//    on accept. If the owner drops cen while locked: clear lock, mem_cen=0.
//  - Arbitration:
//    - ARB_MODE=1: single requester wins. On a tie, the requester not equal to
//      last_win wins. last_win updates on every accept.
//    - ARB_MODE=0: CPU wins ties unless cop_wait >= STARVE_LIMIT.
//    - cop_wait counts cycles with cop_mem_cen=1 and no COP accept; clears on
//      COP accept.
//  - Stall outputs: granted requester sees mem_stall. A non-granted requester
//    with cen=1 sees stall=1. A requester with cen=0 sees stall=0.
//  - Response routing: resp_pend<=accept and resp_owner<=winner.
//    - {cpu,cop}_mem_rdata = mem_rdata (both ports).
//    - x_mem_error = mem_error & resp_pend & (resp_owner==x); 0 otherwise.
//  - Reset (g_resetn=0):
//    - All state cleared: lock=0, resp_pend=0, last_win=COP (CPU wins first
//      tie), cop_wait=0.
//    - Outputs forced: mem_cen=0, both stall=1, both error=0.
//    - A pending response is discarded; a stalled access is dropped.
//
// TESTING
//  - Lone CPU read, addr 0x100, mem_stall=0 -> mem_cen=1, mem_addr=0x100 same
//    cycle; next cycle cpu_mem_rdata=mem_rdata, cop_mem_error=0.
//  - ARB_MODE=1, both request every cycle, mem_stall=0 -> grants alternate
//    CPU,COP,CPU,COP; losing requester sees stall=1 each cycle.
//  - COP granted, mem_stall=1 for 3 cycles while CPU requests -> mem_addr
//    holds the COP addr all 3 cycles; CPU granted on the cycle after accept.
//  - ARB_MODE=0, STARVE_LIMIT=4, CPU requests continuously, COP from cycle 0
//    -> COP granted on cycle 4; cop_wait returns to 0.
//  - CPU write accepted, mem_error=1 in resp cycle -> cpu_mem_error=1 for one
//    cycle, cop_mem_error=0.
//  - g_resetn=0 mid-stall with a response pending -> mem_cen=0 and both
//    errors=0 next cycle; after reset, tie goes to CPU.

Source files
------------

// File: rtl/scarv_cop_mem_arb.sv
// Shares one word-aligned memory port between the CPU data port and the COP port.
// The winner drives the port combinationally; the grant locks through stalls and responses return to the issuer.
module scarv_cop_mem_arb #(
  parameter int ARB_MODE     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  output logic        g_clk_req,

  input  logic        cpu_mem_cen,
  input  logic        cpu_mem_wen,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_ben,
  output logic [31:0] cpu_mem_rdata,
  output logic        cpu_mem_stall,
  output logic        cpu_mem_error,

  input  logic        cop_mem_cen,
  input  logic        cop_mem_wen,
  input  logic [31:0] cop_mem_addr,
  input  logic [31:0] cop_mem_wdata,
  input  logic [3:0]  cop_mem_ben,
  output logic [31:0] cop_mem_rdata,
  output logic        cop_mem_stall,
  output logic        cop_mem_error,

  output logic        mem_cen,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_ben,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall,
  input  logic        mem_error
);

  localparam logic       SEL_CPU    = 1'b0;
  localparam logic       SEL_COP    = 1'b1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  logic       lock;
  logic       owner;
  logic       resp_pend;
  logic       resp_owner;
  logic       last_win;
  logic [3:0] cop_wait;

  logic       tie_pick;
  logic       arb_pick;
  logic       winner;
  logic       win_cen;
  logic       accept;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    if (ARB_MODE == 1) begin
      tie_pick = (last_win == SEL_CPU) ? SEL_COP : SEL_CPU;
    end else begin
      tie_pick = (cop_wait >= STARVE_LIM) ? SEL_COP : SEL_CPU;
    end
    if (cpu_mem_cen && cop_mem_cen) begin
      arb_pick = tie_pick;
    end else begin
      arb_pick = cop_mem_cen ? SEL_COP : SEL_CPU;
    end
    // A locked grant ignores new requests; if the owner drops cen, win_cen goes low.
    winner  = lock ? owner : arb_pick;
    win_cen = (winner == SEL_COP) ? cop_mem_cen : cpu_mem_cen;
  end

  assign mem_cen   = g_resetn & win_cen;
  assign mem_wen   = (winner == SEL_COP) ? cop_mem_wen   : cpu_mem_wen;
  assign mem_addr  = (winner == SEL_COP) ? cop_mem_addr  : cpu_mem_addr;
  assign mem_wdata = (winner == SEL_COP) ? cop_mem_wdata : cpu_mem_wdata;
  assign mem_ben   = (winner == SEL_COP) ? cop_mem_ben   : cpu_mem_ben;
  assign accept    = mem_cen & ~mem_stall;

  assign cpu_mem_stall = ~g_resetn |
                         ((winner == SEL_CPU) ? (cpu_mem_cen & mem_stall) : cpu_mem_cen);
  assign cop_mem_stall = ~g_resetn |
                         ((winner == SEL_COP) ? (cop_mem_cen & mem_stall) : cop_mem_cen);

  assign cpu_mem_rdata = mem_rdata;
  assign cop_mem_rdata = mem_rdata;
  assign cpu_mem_error = g_resetn & mem_error & resp_pend & (resp_owner == SEL_CPU);
  assign cop_mem_error = g_resetn & mem_error & resp_pend & (resp_owner == SEL_COP);

  assign g_clk_req = cpu_mem_cen | cop_mem_cen | resp_pend;

  // Request stage -> response stage: accept in this cycle means rdata/error next cycle.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      lock       <= 1'b0;
      owner      <= SEL_CPU;
      resp_pend  <= 1'b0;
      resp_owner <= SEL_CPU;
      last_win   <= SEL_COP;
      cop_wait   <= 4'd0;
    end else begin
      lock       <= mem_cen & mem_stall;
      owner      <= winner;
      resp_pend  <= accept;
      resp_owner <= winner;
      if (accept) begin
        last_win <= winner;
      end
      if (accept && (winner == SEL_COP)) begin
        cop_wait <= 4'd0;
      end else if (cop_mem_cen) begin
        cop_wait <= sat_inc(cop_wait);
      end
    end
  end

endmodule

// File: tb/tb_scarv_cop_mem_arb.sv
// Directed bench for scarv_cop_mem_arb: round-robin instance with a response scoreboard,
// plus a fixed-priority instance for the COP anti-starvation behaviour.
module tb_scarv_cop_mem_arb;

  localparam logic CPU = 1'b0;
  localparam logic COP = 1'b1;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        cpu_mem_cen, cpu_mem_wen;
  logic [31:0] cpu_mem_addr, cpu_mem_wdata;
  logic [3:0]  cpu_mem_ben;
  logic        cop_mem_cen, cop_mem_wen;
  logic [31:0] cop_mem_addr, cop_mem_wdata;
  logic [3:0]  cop_mem_ben;
  logic [31:0] mem_rdata;
  logic        mem_stall, mem_error;

  logic        rr_clk_req, rr_cpu_stall, rr_cpu_error, rr_cop_stall, rr_cop_error;
  logic [31:0] rr_cpu_rdata, rr_cop_rdata;
  logic        rr_mem_cen, rr_mem_wen;
  logic [31:0] rr_mem_addr, rr_mem_wdata;
  logic [3:0]  rr_mem_ben;

  logic        fp_clk_req, fp_cpu_stall, fp_cpu_error, fp_cop_stall, fp_cop_error;
  logic [31:0] fp_cpu_rdata, fp_cop_rdata;
  logic        fp_mem_cen, fp_mem_wen;
  logic [31:0] fp_mem_addr, fp_mem_wdata;
  logic [3:0]  fp_mem_ben;

  typedef struct {
    logic        who;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t sb[$];
  resp_t cur;
  logic  have_resp;
  int    checks = 0;
  int    errors = 0;

  always #5 g_clk = ~g_clk;

  scarv_cop_mem_arb #(.ARB_MODE(1), .STARVE_LIMIT(4)) u_rr (
    .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(rr_clk_req),
    .cpu_mem_cen(cpu_mem_cen), .cpu_mem_wen(cpu_mem_wen), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_ben(cpu_mem_ben), .cpu_mem_rdata(rr_cpu_rdata),
    .cpu_mem_stall(rr_cpu_stall), .cpu_mem_error(rr_cpu_error),
    .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen), .cop_mem_addr(cop_mem_addr),
    .cop_mem_wdata(cop_mem_wdata), .cop_mem_ben(cop_mem_ben), .cop_mem_rdata(rr_cop_rdata),
    .cop_mem_stall(rr_cop_stall), .cop_mem_error(rr_cop_error),
    .mem_cen(rr_mem_cen), .mem_wen(rr_mem_wen), .mem_addr(rr_mem_addr),
    .mem_wdata(rr_mem_wdata), .mem_ben(rr_mem_ben), .mem_rdata(mem_rdata),
    .mem_stall(mem_stall), .mem_error(mem_error)
  );

  scarv_cop_mem_arb #(.ARB_MODE(0), .STARVE_LIMIT(4)) u_fp (
    .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(fp_clk_req),
    .cpu_mem_cen(cpu_mem_cen), .cpu_mem_wen(cpu_mem_wen), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_ben(cpu_mem_ben), .cpu_mem_rdata(fp_cpu_rdata),
    .cpu_mem_stall(fp_cpu_stall), .cpu_mem_error(fp_cpu_error),
    .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen), .cop_mem_addr(cop_mem_addr),
    .cop_mem_wdata(cop_mem_wdata), .cop_mem_ben(cop_mem_ben), .cop_mem_rdata(fp_cop_rdata),
    .cop_mem_stall(fp_cop_stall), .cop_mem_error(fp_cop_error),
    .mem_cen(fp_mem_cen), .mem_wen(fp_mem_wen), .mem_addr(fp_mem_addr),
    .mem_wdata(fp_mem_wdata), .mem_ben(fp_mem_ben), .mem_rdata(mem_rdata),
    .mem_stall(mem_stall), .mem_error(mem_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Start a cycle; act as the memory and return the response expected for last cycle's accept.
  task automatic begin_cycle();
    @(posedge g_clk);
    #1;
    if (sb.size() != 0) begin
      cur       = sb.pop_front();
      have_resp = 1'b1;
      mem_rdata = cur.rdata;
      mem_error = cur.err;
    end else begin
      have_resp = 1'b0;
      mem_rdata = 32'hDEAD_0000 | 32'($urandom_range(0, 255));
      mem_error = 1'b1;
    end
  endtask

  task automatic idle();
    cpu_mem_cen = 1'b0;
    cop_mem_cen = 1'b0;
    mem_stall   = 1'b0;
  endtask

  task automatic check_resp();
    if (have_resp) begin
      chk("resp_cpu_rdata", rr_cpu_rdata, cur.rdata);
      chk("resp_cop_rdata", rr_cop_rdata, cur.rdata);
      chkb("resp_cpu_error", rr_cpu_error, cur.err & (cur.who == CPU));
      chkb("resp_cop_error", rr_cop_error, cur.err & (cur.who == COP));
    end else begin
      chkb("noresp_cpu_error", rr_cpu_error, 1'b0);
      chkb("noresp_cop_error", rr_cop_error, 1'b0);
    end
  endtask

  task automatic expect_grant(input logic who, input logic err, input string tag);
    resp_t r;
    chkb({tag, "_cen"}, rr_mem_cen, 1'b1);
    chk({tag, "_addr"}, rr_mem_addr, (who == COP) ? cop_mem_addr : cpu_mem_addr);
    chkb({tag, "_wen"}, rr_mem_wen, (who == COP) ? cop_mem_wen : cpu_mem_wen);
    chk({tag, "_wdata"}, rr_mem_wdata, (who == COP) ? cop_mem_wdata : cpu_mem_wdata);
    chk({tag, "_ben"}, {28'd0, rr_mem_ben}, {28'd0, (who == COP) ? cop_mem_ben : cpu_mem_ben});
    chkb({tag, "_cpu_stall"}, rr_cpu_stall, (who == CPU) ? mem_stall : cpu_mem_cen);
    chkb({tag, "_cop_stall"}, rr_cop_stall, (who == COP) ? mem_stall : cop_mem_cen);
    if (!mem_stall) begin
      r.who   = who;
      r.err   = err;
      r.rdata = $urandom;
      sb.push_back(r);
    end
  endtask

  task automatic expect_none(input string tag);
    chkb({tag, "_cen"}, rr_mem_cen, 1'b0);
    chkb({tag, "_cpu_stall"}, rr_cpu_stall, cpu_mem_cen);
    chkb({tag, "_cop_stall"}, rr_cop_stall, cop_mem_cen);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic alt_exp [3];
    alt_exp[0] = COP; alt_exp[1] = CPU; alt_exp[2] = COP;

    g_resetn = 1'b0;
    cpu_mem_cen = 1'b1; cpu_mem_wen = 1'b0; cpu_mem_addr = 32'h0; cpu_mem_wdata = 32'h0; cpu_mem_ben = 4'hF;
    cop_mem_cen = 1'b1; cop_mem_wen = 1'b0; cop_mem_addr = 32'h0; cop_mem_wdata = 32'h0; cop_mem_ben = 4'hF;
    mem_stall = 1'b0; mem_error = 1'b1; mem_rdata = 32'h0;

    // Reset: outputs forced even with both requesting and mem_error high.
    begin_cycle();
    begin_cycle();
    @(negedge g_clk);
    chkb("rst_mem_cen", rr_mem_cen, 1'b0);
    chkb("rst_cpu_stall", rr_cpu_stall, 1'b1);
    chkb("rst_cop_stall", rr_cop_stall, 1'b1);
    chkb("rst_cpu_error", rr_cpu_error, 1'b0);
    chkb("rst_cop_error", rr_cop_error, 1'b0);
    chkb("rst_fp_mem_cen", fp_mem_cen, 1'b0);
    sb.delete();

    begin_cycle(); g_resetn = 1'b1; idle();
    @(negedge g_clk);
    check_resp();
    expect_none("idle");
    chkb("idle_clk_req", rr_clk_req, 1'b0);

    // Lone CPU read at 0x100.
    begin_cycle();
    cpu_mem_cen = 1'b1; cpu_mem_wen = 1'b0; cpu_mem_addr = 32'h100; cpu_mem_wdata = 32'h0; cpu_mem_ben = 4'hF;
    @(negedge g_clk);
    check_resp();
    expect_grant(CPU, 1'b0, "lone_cpu");
    begin_cycle(); idle();
    @(negedge g_clk);
    check_resp();
    chkb("resp_clk_req", rr_clk_req, 1'b1);

    // Round-robin alternation with both requesting every cycle.
    for (int i = 0; i < 3; i++) begin
      begin_cycle();
      cpu_mem_cen = 1'b1; cpu_mem_wen = 1'b1; cpu_mem_addr = 32'h200 + 32'(i * 4);
      cpu_mem_wdata = 32'h1111_0000 + 32'(i); cpu_mem_ben = 4'h3;
      cop_mem_cen = 1'b1; cop_mem_wen = 1'b0; cop_mem_addr = 32'h300 + 32'(i * 4);
      cop_mem_wdata = 32'h2222_0000 + 32'(i); cop_mem_ben = 4'hC;
      @(negedge g_clk);
      check_resp();
      expect_grant(alt_exp[i], (i == 1), "rr_alt");
    end

    // COP stalled and locked while CPU joins; unlocked arbitration would pick CPU.
    begin_cycle(); cpu_mem_cen = 1'b0; cop_mem_addr = 32'h400; mem_stall = 1'b1;
    @(negedge g_clk); check_resp(); expect_grant(COP, 1'b0, "stall1");
    for (int i = 0; i < 2; i++) begin
      begin_cycle(); cpu_mem_cen = 1'b1; cpu_mem_addr = 32'h500; mem_stall = 1'b1;
      @(negedge g_clk); check_resp(); expect_grant(COP, 1'b0, "stall_hold");
    end
    begin_cycle(); mem_stall = 1'b0;
    @(negedge g_clk); check_resp(); expect_grant(COP, 1'b0, "stall_accept");
    begin_cycle();
    @(negedge g_clk); check_resp(); expect_grant(CPU, 1'b0, "after_accept");

    // Owner drops cen while locked: nobody is granted that cycle.
    begin_cycle(); cop_mem_cen = 1'b0; mem_stall = 1'b1;
    @(negedge g_clk); check_resp(); expect_grant(CPU, 1'b0, "lock_cpu");
    begin_cycle(); cpu_mem_cen = 1'b0; cop_mem_cen = 1'b1; mem_stall = 1'b0;
    @(negedge g_clk); check_resp(); expect_none("owner_drop");
    begin_cycle();
    @(negedge g_clk); check_resp(); expect_grant(COP, 1'b0, "after_drop");

    // CPU write with an error response.
    begin_cycle(); cop_mem_cen = 1'b0; cpu_mem_cen = 1'b1; cpu_mem_wen = 1'b1; cpu_mem_addr = 32'h600;
    @(negedge g_clk); check_resp(); expect_grant(CPU, 1'b1, "cpu_wr_err");
    begin_cycle(); idle();
    @(negedge g_clk); check_resp();
    begin_cycle(); idle();
    @(negedge g_clk); check_resp();

    // Reset while COP stalls and a CPU response is pending.
    begin_cycle(); cpu_mem_cen = 1'b1; cpu_mem_wen = 1'b0; cpu_mem_addr = 32'h700;
    @(negedge g_clk); check_resp(); expect_grant(CPU, 1'b1, "pre_rst");
    begin_cycle(); g_resetn = 1'b0; cpu_mem_cen = 1'b0; cop_mem_cen = 1'b1; cop_mem_addr = 32'h704; mem_stall = 1'b1;
    @(negedge g_clk);
    chkb("midrst_mem_cen", rr_mem_cen, 1'b0);
    chkb("midrst_cpu_error", rr_cpu_error, 1'b0);
    chkb("midrst_cop_error", rr_cop_error, 1'b0);
    chkb("midrst_cpu_stall", rr_cpu_stall, 1'b1);
    chkb("midrst_cop_stall", rr_cop_stall, 1'b1);
    sb.delete();
    begin_cycle(); g_resetn = 1'b1; idle();
    @(negedge g_clk); check_resp(); expect_none("post_rst");
    begin_cycle(); cpu_mem_cen = 1'b1; cop_mem_cen = 1'b1; cpu_mem_addr = 32'h708; cop_mem_addr = 32'h70C;
    @(negedge g_clk); check_resp(); expect_grant(CPU, 1'b0, "post_rst_tie");
    begin_cycle(); idle();
    @(negedge g_clk); check_resp();

    // Fixed priority with anti-starvation: COP forced through on cycles 4 and 9.
    begin_cycle(); g_resetn = 1'b0; idle();
    @(negedge g_clk);
    sb.delete();
    for (int i = 0; i < 10; i++) begin
      logic cop_exp;
      begin_cycle(); g_resetn = 1'b1;
      cpu_mem_cen = 1'b1; cpu_mem_addr = 32'h800 + 32'(i * 4);
      cop_mem_cen = 1'b1; cop_mem_addr = 32'h900 + 32'(i * 4);
      mem_stall = 1'b0;
      @(negedge g_clk);
      cop_exp = (i == 4) || (i == 9);
      chk("fp_addr", fp_mem_addr, cop_exp ? cop_mem_addr : cpu_mem_addr);
      chkb("fp_cpu_stall", fp_cpu_stall, cop_exp);
      chkb("fp_cop_stall", fp_cop_stall, ~cop_exp);
    end

    begin_cycle(); idle();
    @(negedge g_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
